me_frame_sequencer: RTL

Frame-level sequencer that sits directly downstream of `control_unit`. It steps through the macroblocks of a frame and runs one full-search request per block using `control_unit`'s req/ack protocol. When each `ack` rises, it captures the winning SAD and motion vector. Captured results are queued in a small FWFT FIFO and drained over a valid/ready result stream toward the host/bus side of the design.

---
 rtl/me_pkg.sv | 25 ++
 rtl/me_frame_sequencer_if.sv | 37 +++
 rtl/me_frame_sequencer_result_fifo.sv | 61 ++++++
 rtl/me_frame_sequencer.sv | 104 ++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// me_pkg: shared widths, sequencer state encoding and result record for the
// motion-estimation frame sequencer slice.
`timescale 1ns/1ps
`default_nettype none

package me_pkg;

    localparam int SAD_WIDTH      = 16;
    localparam int CNT_WIDTH      = 12;
    localparam int MB_FIELD_WIDTH = 16;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_FALL = 2'd3;

    typedef struct packed {
        logic [MB_FIELD_WIDTH-1:0] mb;
        logic [SAD_WIDTH-1:0]      sad;
        logic [CNT_WIDTH-1:0]      mvec;
    } me_result_t;

endpackage

`default_nettype wire

// File: rtl/me_frame_sequencer_if.sv
// me_frame_sequencer_if: search req/ack handshake toward control_unit plus the
// valid/ready result stream toward the host side.
`timescale 1ns/1ps
`default_nettype none

interface me_frame_sequencer_if #(
    parameter int SAD_WIDTH = 16,
    parameter int CNT_WIDTH = 12,
    parameter int IDX_WIDTH = 4
);
    logic                 req;
    logic                 ack;
    logic [SAD_WIDTH-1:0] min_sad;
    logic [CNT_WIDTH-1:0] min_mvec;

    logic                 res_valid;
    logic                 res_ready;
    logic [IDX_WIDTH-1:0] res_mb;
    logic [SAD_WIDTH-1:0] res_sad;
    logic [CNT_WIDTH-1:0] res_mvec;

    modport master (
        output req,
        input  ack, min_sad, min_mvec,
        output res_valid, res_mb, res_sad, res_mvec,
        input  res_ready
    );

    modport slave (
        input  req,
        output ack, min_sad, min_mvec,
        input  res_valid, res_mb, res_sad, res_mvec,
        output res_ready
    );
endinterface

`default_nettype wire

// File: rtl/me_frame_sequencer_result_fifo.sv
// me_result_fifo: first-word-fall-through FIFO with occupancy count; the head
// entry is visible on the cycle after it is written.
`timescale 1ns/1ps
`default_nettype none

module me_result_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int                   PTR_WIDTH = $clog2(DEPTH);
    localparam logic [PTR_WIDTH:0]   FULL      = (PTR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/me_frame_sequencer.sv
// me_frame_sequencer: walks a frame's macroblocks, issues one search per block
// and queues {mb, sad, mvec}. Optional ME_SEQ_FRAME_SAD_EN adds a frame SAD total.
`timescale 1ns/1ps
`default_nettype none

module me_frame_sequencer
    import me_pkg::*;
#(
    parameter int SAD_WIDTH  = me_pkg::SAD_WIDTH,
    parameter int CNT_WIDTH  = me_pkg::CNT_WIDTH,
    parameter int MB_COUNT   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_WIDTH  = (MB_COUNT > 1) ? $clog2(MB_COUNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
`ifdef ME_SEQ_FRAME_SAD_EN
    output logic [SAD_WIDTH+IDX_WIDTH-1:0] frame_sad,
`endif
    output logic [IDX_WIDTH-1:0] mb_idx,
    me_frame_sequencer_if.master bus
);
    localparam int                   RES_WIDTH  = IDX_WIDTH + SAD_WIDTH + CNT_WIDTH;
    localparam int                   FCNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(MB_COUNT - 1);
    localparam logic [FCNT_WIDTH-1:0] FIFO_FULL = FCNT_WIDTH'(FIFO_DEPTH);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  req_r;
    logic                  push;
    logic                  last_fall;
    logic [FCNT_WIDTH-1:0] fifo_count;
    logic [RES_WIDTH-1:0]  head;

    assign push      = (state == S_WAIT_ACK) && bus.ack;
    assign last_fall = (state == S_WAIT_FALL) && !bus.ack && (mb_idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start)                   state_nxt = S_ISSUE;
            S_ISSUE:     if (fifo_count < FIFO_FULL)  state_nxt = S_WAIT_ACK;
            S_WAIT_ACK:  if (bus.ack)                 state_nxt = S_WAIT_FALL;
            S_WAIT_FALL: if (!bus.ack)                state_nxt = last_fall ? S_IDLE : S_ISSUE;
            default:                                  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_r      <= 1'b0;
            frame_done <= 1'b0;
            mb_idx     <= '0;
        end else begin
            state      <= state_nxt;
            req_r      <= (state_nxt == S_WAIT_ACK);
            frame_done <= last_fall;
            if (state == S_IDLE && start) begin
                mb_idx <= '0;
            end else if (state == S_WAIT_FALL && !bus.ack && !last_fall) begin
                mb_idx <= mb_idx + 1'b1;
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign bus.req = req_r;

`ifdef ME_SEQ_FRAME_SAD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_sad <= '0;
        end else if (state == S_IDLE && start) begin
            frame_sad <= '0;
        end else if (push) begin
            frame_sad <= frame_sad + (SAD_WIDTH+IDX_WIDTH)'(bus.min_sad);
        end
    end
`endif

    me_result_fifo #(
        .WIDTH (RES_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({mb_idx, bus.min_sad, bus.min_mvec}),
        .pop       (bus.res_ready),
        .valid     (bus.res_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign {bus.res_mb, bus.res_sad, bus.res_mvec} = head;

endmodule

`default_nettype wire
